// File: rtl/ram_access_ctrl.sv
// rtl/ram_access_ctrl.sv - single-port RAM access controller with programmable wait states
module ram_access_ctrl #(
    parameter int                 ADDR_W     = 12,
    parameter int                 DATA_W     = 8,
    parameter logic [ADDR_W-1:0]  MEM_TOP    = 12'hFFF,
    parameter logic [3:0]         RESET_WAIT = 4'd2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req,
    input  logic              r_wb,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              cfg_we,
    input  logic [3:0]        cfg_wait,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic              ram_cs,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS   = 2'd1,
        COMPLETE = 2'd2,
        ERROR    = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          wcnt_q, wcnt_d;
    logic [3:0]          wait_q, wait_d;
    logic                rwb_q, rwb_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                ram_cs_q, ram_cs_d;
    logic                ram_we_q, ram_we_d;

    // Next-state logic; outputs are decoded from the next state so every output is a flop
    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        rwb_d       = rwb_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        rdata_d     = rdata_q;
        // The wait register is independent of the FSM; an accepted request already
        // sampled the old value into wcnt on this same edge.
        wait_d      = cfg_we ? cfg_wait : wait_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    rwb_d  = r_wb;
                    wcnt_d = wait_q;
                    if (addr > MEM_TOP) begin
                        // Bad address never reaches the RAM pins, so ram_addr keeps its last value
                        state_d = ERROR;
                    end else begin
                        state_d     = ACCESS;
                        ram_addr_d  = addr;
                        ram_wdata_d = wdata;
                    end
                end
            end
            ACCESS: begin
                if (wcnt_q == 4'd0) begin
                    state_d = COMPLETE;
                    if (rwb_q) begin
                        rdata_d = ram_rdata;
                    end
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            COMPLETE: state_d = IDLE;
            ERROR:    state_d = IDLE;
            default:  state_d = IDLE;
        endcase

        busy_d   = (state_d != IDLE);
        done_d   = (state_d == COMPLETE) || (state_d == ERROR);
        err_d    = (state_d == ERROR);
        ram_cs_d = (state_d == ACCESS);
        ram_we_d = (state_d == ACCESS) && !rwb_d;
    end

    // State and registered outputs; reset aborts any transaction without a done pulse
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            wcnt_q      <= 4'd0;
            wait_q      <= RESET_WAIT;
            rwb_q       <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            rdata_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            ram_cs_q    <= 1'b0;
            ram_we_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            wait_q      <= wait_d;
            rwb_q       <= rwb_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            rdata_q     <= rdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            ram_cs_q    <= ram_cs_d;
            ram_we_q    <= ram_we_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign ram_cs    = ram_cs_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// tb/tb_ram_access_ctrl.sv - directed vector bench for ram_access_ctrl
module tb_ram_access_ctrl;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req;
    logic        r_wb;
    logic [11:0] addr;
    logic [7:0]  wdata;
    logic        cfg_we;
    logic [3:0]  cfg_wait;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  rdata;
    logic        ram_cs;
    logic        ram_we;
    logic [11:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    ram_access_ctrl #(
        .ADDR_W     (12),
        .DATA_W     (8),
        .MEM_TOP    (12'h7FF),
        .RESET_WAIT (4'd2)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req       (req),
        .r_wb      (r_wb),
        .addr      (addr),
        .wdata     (wdata),
        .cfg_we    (cfg_we),
        .cfg_wait  (cfg_wait),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .ram_cs    (ram_cs),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    typedef struct {
        logic        do_cfg;
        logic [3:0]  cfg;
        logic        rwb;
        logic [11:0] a;
        logic [7:0]  wd;
        logic [7:0]  rrd;
        int          exp_acc;
        int          exp_done;
        logic        exp_err;
        logic [7:0]  exp_rdata;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cfg_write(input logic [3:0] w);
        cfg_we   = 1'b1;
        cfg_wait = w;
        @(posedge clock);
        @(negedge clock);
        cfg_we   = 1'b0;
    endtask

    // Issues one request and checks the whole transaction against the vector
    task automatic do_txn(input vec_t v, input string tag);
        int   acc;
        int   done_k;
        logic bad;
        logic err_at;
        logic [7:0] rd_at;
        if (v.do_cfg) cfg_write(v.cfg);
        req       = 1'b1;
        r_wb      = v.rwb;
        addr      = v.a;
        wdata     = v.wd;
        ram_rdata = v.rrd;
        @(posedge clock);
        @(negedge clock);
        req   = 1'b0;
        r_wb  = ~v.rwb;
        addr  = ~v.a;
        wdata = ~v.wd;
        acc    = 0;
        done_k = 0;
        bad    = 1'b0;
        err_at = 1'b0;
        rd_at  = 8'h00;
        for (int k = 1; k <= 40 && done_k == 0; k++) begin
            if (ram_cs) begin
                acc++;
                if (ram_we !== ~v.rwb || ram_addr !== v.a || ram_wdata !== v.wd) bad = 1'b1;
            end else if (ram_we) begin
                bad = 1'b1;
            end
            if (!busy) bad = 1'b1;
            if (done) begin
                done_k = k;
                err_at = err;
                rd_at  = rdata;
            end else begin
                @(negedge clock);
            end
        end
        chk({tag, " access_cycles"}, acc, v.exp_acc);
        chk({tag, " done_cycle"}, done_k, v.exp_done);
        chk({tag, " err"}, err_at, v.exp_err);
        chk({tag, " rdata_at_done"}, rd_at, v.exp_rdata);
        chk({tag, " ram_pins"}, bad, 1'b0);
        @(negedge clock);
        chk({tag, " after_done"}, {done, err, busy, ram_cs, rdata}, {4'b0000, v.exp_rdata});
    endtask

    logic [16:0] cs_tr, we_tr, done_tr, busy_tr;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b0, 4'd0,  1'b0, 12'h123, 8'h11, 8'hEE, 3,  4,  1'b0, 8'h00};
        vecs[1] = '{1'b1, 4'd2,  1'b0, 12'h0A5, 8'h3C, 8'hFF, 3,  4,  1'b0, 8'h00};
        vecs[2] = '{1'b1, 4'd0,  1'b1, 12'h010, 8'h00, 8'h5A, 1,  2,  1'b0, 8'h5A};
        vecs[3] = '{1'b0, 4'd0,  1'b1, 12'h800, 8'h00, 8'h77, 0,  1,  1'b1, 8'h5A};
        vecs[4] = '{1'b1, 4'd3,  1'b1, 12'h7FF, 8'h00, 8'hA6, 4,  5,  1'b0, 8'hA6};
        vecs[5] = '{1'b0, 4'd0,  1'b0, 12'hFFF, 8'h55, 8'h33, 0,  1,  1'b1, 8'hA6};
        vecs[6] = '{1'b1, 4'd15, 1'b0, 12'h000, 8'hFF, 8'h99, 16, 17, 1'b0, 8'hA6};
        vecs[7] = '{1'b1, 4'd1,  1'b1, 12'h456, 8'h00, 8'h0C, 2,  3,  1'b0, 8'h0C};

        reset_n   = 1'b0;
        req       = 1'b0;
        r_wb      = 1'b0;
        addr      = 12'h000;
        wdata     = 8'h00;
        cfg_we    = 1'b0;
        cfg_wait  = 4'd0;
        ram_rdata = 8'h00;
        repeat (2) @(negedge clock);
        chk("reset_outputs", {busy, done, err, ram_cs, ram_we, ram_addr, ram_wdata, rdata}, 32'h0);
        reset_n = 1'b1;

        // Vector 0 is accepted on the first edge after reset, with the reset wait count
        for (int i = 0; i < 8; i++) begin
            do_txn(vecs[i], $sformatf("vec%0d", i));
        end

        // Config race: new wait loaded on the acceptance edge, req held high, reload mid-flight
        cfg_write(4'd2);
        req      = 1'b1;
        r_wb     = 1'b0;
        addr     = 12'h300;
        wdata    = 8'h44;
        cfg_we   = 1'b1;
        cfg_wait = 4'd7;
        @(posedge clock);
        cs_tr = '0; we_tr = '0; done_tr = '0; busy_tr = '0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clock);
            if (k == 1) cfg_we = 1'b0;
            cs_tr[k]   = ram_cs;
            we_tr[k]   = ram_we;
            done_tr[k] = done;
            busy_tr[k] = busy;
            if (k == 7) begin
                cfg_we   = 1'b1;
                cfg_wait = 4'd0;
            end
            if (k == 8)  cfg_we = 1'b0;
            if (k == 14) req = 1'b0;
        end
        chk("race ram_cs trace", cs_tr,   17'b00011111111001110);
        chk("race ram_we trace", we_tr,   17'b00011111111001110);
        chk("race done trace",   done_tr, 17'b00100000000010000);
        chk("race busy trace",   busy_tr, 17'b00111111111011110);
        do_txn('{1'b0, 4'd0, 1'b1, 12'h234, 8'h00, 8'hC3, 1, 2, 1'b0, 8'hC3}, "post_race");

        // Abort: reset in the second ACCESS cycle of a wait=5 write
        cfg_write(4'd5);
        req   = 1'b1;
        r_wb  = 1'b0;
        addr  = 12'h055;
        wdata = 8'hAA;
        @(posedge clock);
        @(negedge clock);
        req = 1'b0;
        @(negedge clock);
        chk("abort cs_before", {ram_cs, ram_we}, 2'b11);
        reset_n = 1'b0;
        #1;
        chk("abort immediate", {ram_cs, ram_we, busy, done, err, rdata}, 13'h0);
        begin
            logic saw_done;
            saw_done = 1'b0;
            for (int k = 0; k < 8; k++) begin
                @(negedge clock);
                if (k == 2) reset_n = 1'b1;
                if (done || busy) saw_done = 1'b1;
            end
            chk("abort no_done", saw_done, 1'b0);
        end
        do_txn('{1'b0, 4'd0, 1'b1, 12'h0F0, 8'h00, 8'h81, 3, 4, 1'b0, 8'h81}, "post_abort");

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ram_access_ctrl.md
RAM_ACCESS_CTRL -- requirements
Module: ram_access_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 12, the address width.
REQ-002 The block SHALL have parameter DATA_W, default 8, the data width.
REQ-003 The block SHALL have parameter MEM_TOP, default 12'hFFF, the highest legal RAM address.
REQ-004 The block SHALL have parameter RESET_WAIT, default 4'd2, the wait-state count loaded at reset.
REQ-005 The block SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port reset_n, input, 1: reset is asynchronous and active-low.
REQ-007 The block SHALL have port req, input, 1, transaction request from the granted bus master.
REQ-008 The block SHALL have port r_wb, input, 1, read (1) / write_n (0) for the request.
REQ-009 The block SHALL have port addr, input, ADDR_W, request address.
REQ-010 The block SHALL have port wdata, input, DATA_W, write data.
REQ-011 The block SHALL have port cfg_we, input, 1, loads cfg_wait into the wait-state register.
REQ-012 The block SHALL have port cfg_wait, input, 4, wait-state count, 0..15.
REQ-013 The block SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-014 The block SHALL have port done, output, 1, one-cycle completion pulse.
REQ-015 The block SHALL have port err, output, 1, one-cycle pulse with done on an out-of-range address.
REQ-016 The block SHALL have port rdata, output, DATA_W, last completed read data.
REQ-017 The block SHALL have ports ram_cs (output, 1), ram_we (output, 1), ram_addr (output, ADDR_W) and ram_wdata (output, DATA_W), driving the RAM.
REQ-018 The block SHALL have port ram_rdata, input, DATA_W, RAM read data, valid while ram_cs=1 and ram_we=0.

Function
REQ-019 FSM states SHALL be IDLE, ACCESS, COMPLETE, ERROR; all outputs SHALL be registered (Moore).
REQ-020 IDLE + req=1 at a clock edge SHALL accept the transaction: latch r_wb, addr, wdata; load wcnt from the wait register.
REQ-021 An accepted addr > MEM_TOP SHALL go to ERROR, never to ACCESS; otherwise the FSM SHALL go to ACCESS.
REQ-022 ACCESS SHALL drive ram_cs=1, ram_we=~latched r_wb, ram_addr=latched addr, ram_wdata=latched wdata.
REQ-023 In ACCESS, wcnt SHALL decrement by 1 per cycle; the FSM SHALL leave ACCESS to COMPLETE on the edge where wcnt==0, giving exactly wait+1 ACCESS cycles (wait=0 gives 1 cycle).
REQ-024 For a read, rdata SHALL capture ram_rdata on the ACCESS-to-COMPLETE edge.
REQ-025 rdata SHALL be unchanged by writes and errors.
REQ-026 COMPLETE SHALL assert done=1 and ram_cs=0 for one cycle, then go to IDLE unconditionally.
REQ-027 ERROR SHALL assert done=1, err=1 and ram_cs=0 for one cycle, then go to IDLE.
REQ-028 Latency SHALL be: done high in cycle wait+2 after the acceptance edge; the next request SHALL be accepted no earlier than the edge after done.
REQ-029 req deasserted, or addr/wdata/r_wb changing, after acceptance SHALL NOT affect the transaction in flight.
REQ-030 cfg_we=1 SHALL load cfg_wait at the clock edge in any state; the transaction in flight SHALL keep its snapshot.
REQ-031 If cfg_we and acceptance occur on the same edge, the accepted transaction SHALL use the old wait value.
REQ-032 Outside ACCESS, ram_cs and ram_we SHALL be 0; ram_addr and ram_wdata SHALL hold their last values.

Reset
REQ-033 reset_n=0 SHALL immediately force state IDLE, busy=0, done=0, err=0, ram_cs=0, ram_we=0, ram_addr=0, ram_wdata=0, rdata=0, wcnt=0, and wait register=RESET_WAIT.
REQ-034 reset_n asserted mid-transaction SHALL abort it with no done pulse.
REQ-035 The first acceptance after reset SHALL be possible on the first rising edge with reset_n=1.

Verification
REQ-036 Reset: drive reset_n=0 -> all outputs 0 and busy=0; a transaction with cfg never written uses 3 ACCESS cycles.
REQ-037 Write, wait=2, addr=12'h0A5, wdata=8'h3C: ram_cs=ram_we=1 with ram_addr=12'h0A5, ram_wdata=8'h3C for exactly 3 cycles; done pulses in cycle 4; rdata unchanged.
REQ-038 Read, cfg_wait=0, addr=12'h010, ram_rdata=8'h5A: one ACCESS cycle with ram_we=0; rdata=8'h5A while done=1, held afterwards.
REQ-039 Out-of-range, MEM_TOP=12'h7FF, addr=12'h800: ram_cs stays 0; done=err=1 for one cycle in cycle 1 after acceptance.
REQ-040 Abort: drop reset_n in the 2nd ACCESS cycle of a wait=5 write -> ram_cs=0 immediately; no done; the next request completes normally.
REQ-041 Config race: cfg_we=1 with cfg_wait=7 during a wait=2 transaction -> current transaction has 3 ACCESS cycles, the next has 8; req held high continuously -> one IDLE cycle between transactions.
